// File: rtl/tdm_tx.sv
// Multi-slot I2S/TDM serial audio transmitter with a double-buffered frame and underrun detection.
// Build option: define TDM_TX_REPEAT_EN to retransmit the previous frame on underrun instead of zeros.
module tdm_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLOTS = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic             sclk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sclk_out,
  output logic             ws_out,
  output logic             sdata_out,
  output logic             underrun
);

  localparam int unsigned SW = $clog2(SLOTS);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(SLOTS + 1);

  typedef logic [SLOTS-1:0][WIDTH-1:0] frame_t;

  logic [SW-1:0] r_slot, w_slot_nxt, w_ws_slot, w_idx;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  frame_t        r_stage, w_stage_nxt, r_active, w_active_nxt;
  logic          r_ready, r_ws, r_sdata, r_underrun;
  logic          w_ready_nxt, w_ws_nxt, w_sdata_nxt, w_underrun_nxt;
  logic          w_wrap, w_full, w_accept;

  assign sclk_out     = sclk_in;
  assign sample_ready = r_ready;
  assign ws_out       = r_ws;
  assign sdata_out    = r_sdata;
  assign underrun     = r_underrun;

  assign w_full   = (r_cnt == CW'(SLOTS));
  assign w_wrap   = (r_slot == SW'(SLOTS - 1)) && (r_bit == BW'(WIDTH - 1));
  assign w_accept = sample_valid && r_ready;
  assign w_idx    = r_cnt[SW-1:0];

  // Next position, buffer transfer/underrun handling and registered output values.
  always_comb begin
    w_bit_nxt      = r_bit + BW'(1);
    w_slot_nxt     = r_slot;
    w_stage_nxt    = r_stage;
    w_active_nxt   = r_active;
    w_cnt_nxt      = r_cnt;
    w_underrun_nxt = 1'b0;
    w_ws_slot      = '0;
    w_ws_nxt       = 1'b0;

    if (r_bit == BW'(WIDTH - 1)) begin
      w_bit_nxt  = '0;
      w_slot_nxt = w_wrap ? '0 : r_slot + SW'(1);
    end

    if (w_wrap) begin
      if (w_full) begin
        w_active_nxt = r_stage;
        w_cnt_nxt    = '0;
      end else begin
        w_underrun_nxt = 1'b1;
`ifdef TDM_TX_REPEAT_EN
        w_active_nxt   = r_active;
`else
        w_active_nxt   = '0;
`endif
      end
    end

    // Ready is low whenever staging is full, so an accept never coincides with a transfer.
    if (w_accept) begin
      w_stage_nxt[w_idx] = sample_data;
      w_cnt_nxt          = w_cnt_nxt + CW'(1);
    end

    w_ready_nxt = (w_cnt_nxt < CW'(SLOTS));
    w_sdata_nxt = w_active_nxt[w_slot_nxt][BW'(WIDTH - 1) - w_bit_nxt];

    // Word select leads the data by one bit clock.
    if (MODE == 0) begin
      if (w_bit_nxt == BW'(WIDTH - 1))
        w_ws_slot = (w_slot_nxt == SW'(SLOTS - 1)) ? '0 : w_slot_nxt + SW'(1);
      else
        w_ws_slot = w_slot_nxt;
      w_ws_nxt = (w_ws_slot >= SW'(SLOTS / 2));
    end else begin
      w_ws_nxt = (w_slot_nxt == SW'(SLOTS - 1)) && (w_bit_nxt == BW'(WIDTH - 1));
    end
  end

  always_ff @(posedge sclk_in or negedge rst) begin
    if (!rst) begin
      r_slot     <= '0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_active   <= '0;
      r_ready    <= 1'b1;
      r_ws       <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_bit      <= w_bit_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stage    <= w_stage_nxt;
      r_active   <= w_active_nxt;
      r_ready    <= w_ready_nxt;
      r_ws       <= w_ws_nxt;
      r_sdata    <= w_sdata_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_tx.sv
// Directed bench for tdm_tx: TDM backpressure stream on one instance, I2S frame/underrun/reset sequence on another.
module tb_tdm_tx;

  localparam int NA = 203;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, ready_a, sclko_a, ws_a, sd_a, ur_a;
  logic [15:0] data_a;
  logic        rst_b, valid_b, ready_b, sclko_b, ws_b, sd_b, ur_b;
  logic [7:0]  data_b;

  tdm_tx #(.WIDTH(16), .SLOTS(2), .MODE(0)) u_a (
    .sclk_in(clk), .rst(rst_a), .sample_data(data_a), .sample_valid(valid_a),
    .sample_ready(ready_a), .sclk_out(sclko_a), .ws_out(ws_a), .sdata_out(sd_a), .underrun(ur_a));

  tdm_tx #(.WIDTH(8), .SLOTS(4), .MODE(1)) u_b (
    .sclk_in(clk), .rst(rst_b), .sample_data(data_b), .sample_valid(valid_b),
    .sample_ready(ready_b), .sclk_out(sclko_b), .ws_out(ws_b), .sdata_out(sd_b), .underrun(ur_b));

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        e_sd;
    logic        e_ws;
    logic        e_rdy;
    logic        e_ur;
  } vec_t;

  vec_t        tbl [NA];
  logic [31:0] fr [7];
  logic [7:0]  lst [16] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'hA5,
                           8'h11, 8'h22, 8'h44, 8'h88, 8'hF0, 8'h0F, 8'h69, 8'h96};
  logic [7:0]  sbq [$];
  logic [31:0] cur;
  logic        took;
  int          acc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Staging fill count of instance A after edge e, derived by hand from the stimulus below.
  function automatic int cnt_a(input int e);
    if (e == 0)   return 0;
    if (e <= 1)   return 1;
    if (e <= 31)  return 2;
    if (e <= 39)  return 0;
    if (e <= 69)  return 1;
    if (e <= 95)  return 2;
    if (e <= 139) return 0;
    if (e <= 159) return 1;
    if (e <= 191) return 2;
    if (e == 192) return 0;
    if (e == 193) return 1;
    return 2;
  endfunction

  initial begin
    fr[0] = 32'h0;
    fr[1] = 32'hA5A5_0F0F;
    fr[3] = 32'h1234_5678;
    fr[6] = 32'hBEEF_CAFE;
`ifdef TDM_TX_REPEAT_EN
    fr[2] = 32'hA5A5_0F0F;
    fr[4] = 32'h1234_5678;
    fr[5] = 32'h1234_5678;
`else
    fr[2] = 32'h0;
    fr[4] = 32'h0;
    fr[5] = 32'h0;
`endif
    for (int e = 0; e < NA; e++) begin
      tbl[e].v     = 1'b0;
      tbl[e].d     = 16'h0;
      tbl[e].e_sd  = fr[e / 32][31 - (e % 32)];
      tbl[e].e_ws  = ((e % 32) >= 15) && ((e % 32) <= 30);
      tbl[e].e_rdy = (cnt_a(e) < 2);
      tbl[e].e_ur  = (e == 64) || (e == 128) || (e == 160);
    end
    tbl[1].v   = 1'b1; tbl[1].d   = 16'hA5A5;
    tbl[2].v   = 1'b1; tbl[2].d   = 16'h0F0F;
    tbl[40].v  = 1'b1; tbl[40].d  = 16'h1234;
    tbl[70].v  = 1'b1; tbl[70].d  = 16'h5678;
    tbl[140].v = 1'b1; tbl[140].d = 16'hBEEF;
    tbl[160].v = 1'b1; tbl[160].d = 16'hCAFE;
    tbl[193].v = 1'b1; tbl[193].d = 16'h1111;
    tbl[194].v = 1'b1; tbl[194].d = 16'h2222;

    valid_a = 1'b0; data_a = 16'h0;
    valid_b = 1'b0; data_b = 8'h0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("A reset ready", ready_a, 1);
    chk("A reset sdata", sd_a, 0);
    chk("A reset ws", ws_a, 0);
    chk("A reset underrun", ur_a, 0);
    chk("B reset ready", ready_b, 1);
    chk("B reset sdata", sd_b, 0);

    // Instance B: TDM framing with sample_valid held high throughout.
    @(negedge clk);
    rst_b = 1'b1;
    acc = 0;
    cur = 32'h0;
    chk("B e=0 ready", ready_b, 1);
    valid_b = 1'b1;
    data_b  = lst[0];
    for (int e = 1; e < 128; e++) begin
      took = ready_b && valid_b;
      @(negedge clk);
      if (took) begin
        sbq.push_back(data_b);
        acc++;
      end
      if ((e % 32) == 0) begin
        chk($sformatf("B queue depth e=%0d", e), sbq.size(), 4);
        if (sbq.size() >= 4) begin
          cur = {sbq[0], sbq[1], sbq[2], sbq[3]};
          repeat (4) void'(sbq.pop_front());
        end
        if (e == 32) chk("B first frame word", cur, 32'h0180_FF00);
      end
      chk($sformatf("B ws e=%0d", e), ws_b, ((e % 32) == 31));
      chk($sformatf("B ready e=%0d", e), ready_b, ((e % 32) < 4));
      chk($sformatf("B underrun e=%0d", e), ur_b, 0);
      chk($sformatf("B sdata e=%0d", e), sd_b, (e < 32) ? 1'b0 : cur[31 - (e % 32)]);
      data_b = (acc < 16) ? lst[acc] : 8'h00;
    end
    valid_b = 1'b0;
    chk("B accepted count", acc, 16);
    chk("B staged leftover", sbq.size(), 4);

    // Instance A: I2S frames, underrun, wrap-edge collision, then reset at pos 10.
    @(negedge clk);
    rst_a = 1'b1;
    for (int e = 0; e < NA; e++) begin
      if (e > 0) @(negedge clk);
      chk($sformatf("A sdata e=%0d", e), sd_a, tbl[e].e_sd);
      chk($sformatf("A ws e=%0d", e), ws_a, tbl[e].e_ws);
      chk($sformatf("A ready e=%0d", e), ready_a, tbl[e].e_rdy);
      chk($sformatf("A underrun e=%0d", e), ur_a, tbl[e].e_ur);
      if (e + 1 < NA) begin
        valid_a = tbl[e + 1].v;
        data_a  = tbl[e + 1].d;
      end else begin
        valid_a = 1'b0;
      end
    end
    #2 rst_a = 1'b0;
    #1;
    chk("A mid reset sdata", sd_a, 0);
    chk("A mid reset ready", ready_a, 1);
    chk("A mid reset ws", ws_a, 0);
    chk("A mid reset underrun", ur_a, 0);
    chk("A sclk_out low", sclko_a, clk);
    @(posedge clk);
    #1;
    chk("A sclk_out high", sclko_a, 1);
    chk("A held reset sdata", sd_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    for (int e = 0; e < 64; e++) begin
      if (e > 0) @(negedge clk);
      chk($sformatf("A post sdata e=%0d", e), sd_a, 0);
      chk($sformatf("A post ws e=%0d", e), ws_a, ((e % 32) >= 15) && ((e % 32) <= 30));
      chk($sformatf("A post ready e=%0d", e), ready_a, 1);
      chk($sformatf("A post underrun e=%0d", e), ur_a, (e == 32));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
